// File: rtl/vdma_frame_scheduler.sv
// Frame buffer rotation for a VDMA writer/reader pair: chooses the write and read
// buffers on frame-sync edges, so the writer never targets the buffer being read.
module vdma_frame_scheduler #(
    parameter int          ASIZE        = 29,
    parameter int          BUF_NUM      = 3,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0080_0000
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic             wr_vs,
    input  logic             wr_done,
    input  logic             rd_vs,
    output logic [2:0]       wr_point,
    output logic [2:0]       rd_point,
    output logic [ASIZE-1:0] wr_baseaddr,
    output logic [ASIZE-1:0] rd_baseaddr,
    output logic             frame_valid,
    output logic             rd_new,
    output logic             rd_repeat,
    output logic             wr_overwrite,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      drop_cnt
);

    typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_OPEN = 1'b1} wr_state_t;

    function automatic logic [2:0] buf_step(input logic [2:0] idx, input logic [2:0] inc);
        logic [3:0] sum;
        sum = {1'b0, idx} + {1'b0, inc};
        if (sum >= 4'(BUF_NUM)) begin
            sum = sum - 4'(BUF_NUM);
        end else begin
            sum = sum;
        end
        return sum[2:0];
    endfunction

    function automatic logic [ASIZE-1:0] addr_of(input logic [2:0] point);
        logic [63:0] full;
        full = 64'(BASE_ADDR) + 64'(point) * 64'(FRAME_STRIDE);
        return full[ASIZE-1:0];
    endfunction

    wr_state_t   state_q, state_d;
    logic        wr_cur_q, wr_cur_d, wr_prev_q, wr_prev_d;
    logic        rd_cur_q, rd_cur_d, rd_prev_q, rd_prev_d;
    logic        done_q, done_d, valid_q, valid_d;
    logic [2:0]  wr_point_q, wr_point_d, rd_point_q, rd_point_d, latest_q, latest_d;
    logic        rd_new_q, rd_new_d, rd_repeat_q, rd_repeat_d, overwrite_q, overwrite_d;
    logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
    logic        wr_edge_s, rd_edge_s;
    logic [2:0]  cand1_s, cand2_s;

    assign wr_edge_s = wr_cur_q & ~wr_prev_q;
    assign rd_edge_s = rd_cur_q & ~rd_prev_q;

    // Next-state logic: reader resolves first, writer then steers around the new rd_point.
    always_comb begin
        state_d     = state_q;
        wr_cur_d    = wr_cur_q;
        wr_prev_d   = wr_prev_q;
        rd_cur_d    = rd_cur_q;
        rd_prev_d   = rd_prev_q;
        done_d      = done_q;
        valid_d     = valid_q;
        wr_point_d  = wr_point_q;
        rd_point_d  = rd_point_q;
        latest_d    = latest_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        rd_new_d    = 1'b0;
        rd_repeat_d = 1'b0;
        overwrite_d = 1'b0;
        cand1_s     = buf_step(wr_point_q, 3'd1);
        cand2_s     = buf_step(wr_point_q, 3'd2);
        if (enable) begin
            wr_cur_d  = wr_vs;
            wr_prev_d = wr_cur_q;
            rd_cur_d  = rd_vs;
            rd_prev_d = rd_cur_q;
            if (rd_edge_s) begin
                if (valid_q && (latest_q != rd_point_q)) begin
                    rd_point_d = latest_q;
                    rd_new_d   = 1'b1;
                end else begin
                    rd_repeat_d = 1'b1;
                end
            end else begin
                rd_point_d = rd_point_q;
            end
            case (state_q)
                WR_IDLE: begin
                    if (wr_edge_s) begin
                        state_d = WR_OPEN;
                        done_d  = 1'b0;
                    end else begin
                        state_d = WR_IDLE;
                    end
                end
                WR_OPEN: begin
                    if (wr_edge_s) begin
                        done_d = 1'b0;
                        if (done_q || wr_done) begin
                            latest_d    = wr_point_q;
                            valid_d     = 1'b1;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            if (cand1_s != rd_point_d) begin
                                wr_point_d = cand1_s;
                            end else if ((cand2_s != rd_point_d) && (cand2_s != wr_point_q)) begin
                                wr_point_d = cand2_s;
                            end else begin
                                // No free buffer besides the reader's: rewrite in place.
                                wr_point_d  = wr_point_q;
                                overwrite_d = 1'b1;
                            end
                            if (wr_point_d == latest_d) begin
                                valid_d = 1'b0;
                            end else begin
                                valid_d = 1'b1;
                            end
                        end else begin
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end
                    end else if (wr_done) begin
                        done_d = 1'b1;
                    end else begin
                        done_d = done_q;
                    end
                end
                default: begin
                    state_d = WR_IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State register; every status output is taken from here.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= WR_IDLE;
            wr_cur_q    <= 1'b0;
            wr_prev_q   <= 1'b0;
            rd_cur_q    <= 1'b0;
            rd_prev_q   <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            wr_point_q  <= 3'd0;
            rd_point_q  <= 3'(BUF_NUM - 1);
            latest_q    <= 3'd0;
            frame_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
            rd_new_q    <= 1'b0;
            rd_repeat_q <= 1'b0;
            overwrite_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cur_q    <= wr_cur_d;
            wr_prev_q   <= wr_prev_d;
            rd_cur_q    <= rd_cur_d;
            rd_prev_q   <= rd_prev_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            wr_point_q  <= wr_point_d;
            rd_point_q  <= rd_point_d;
            latest_q    <= latest_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            rd_new_q    <= rd_new_d;
            rd_repeat_q <= rd_repeat_d;
            overwrite_q <= overwrite_d;
        end
    end

    assign wr_point     = wr_point_q;
    assign rd_point     = rd_point_q;
    assign wr_baseaddr  = addr_of(wr_point_q);
    assign rd_baseaddr  = addr_of(rd_point_q);
    assign frame_valid  = valid_q;
    assign rd_new       = rd_new_q;
    assign rd_repeat    = rd_repeat_q;
    assign wr_overwrite = overwrite_q;
    assign frame_cnt    = frame_cnt_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_vdma_frame_scheduler.sv
// Directed bench for vdma_frame_scheduler: a 3-buffer instance for rotation,
// drop, skip, freeze and reset behaviour, plus a 2-buffer instance for overwrite.
module tb_vdma_frame_scheduler;

    logic        clock, rst, enable;
    logic        wr_vs, wr_done, rd_vs;
    logic [2:0]  wr_point, rd_point;
    logic [28:0] wr_baseaddr, rd_baseaddr;
    logic        frame_valid, rd_new, rd_repeat, wr_overwrite;
    logic [15:0] frame_cnt, drop_cnt;

    logic        wr_vs2, wr_done2, rd_vs2;
    logic [2:0]  wr_point2, rd_point2;
    logic [28:0] wr_baseaddr2, rd_baseaddr2;
    logic        frame_valid2, rd_new2, rd_repeat2, wr_overwrite2;
    logic [15:0] frame_cnt2, drop_cnt2;

    int checks = 0;
    int failures = 0;

    vdma_frame_scheduler #(
        .ASIZE(29), .BUF_NUM(3), .BASE_ADDR(32'h0100_0000), .FRAME_STRIDE(32'h0080_0000)
    ) dut (
        .clock(clock), .rst(rst), .enable(enable),
        .wr_vs(wr_vs), .wr_done(wr_done), .rd_vs(rd_vs),
        .wr_point(wr_point), .rd_point(rd_point),
        .wr_baseaddr(wr_baseaddr), .rd_baseaddr(rd_baseaddr),
        .frame_valid(frame_valid), .rd_new(rd_new), .rd_repeat(rd_repeat),
        .wr_overwrite(wr_overwrite), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    vdma_frame_scheduler #(
        .ASIZE(29), .BUF_NUM(2), .BASE_ADDR(32'h0100_0000), .FRAME_STRIDE(32'h0080_0000)
    ) dut2 (
        .clock(clock), .rst(rst), .enable(enable),
        .wr_vs(wr_vs2), .wr_done(wr_done2), .rd_vs(rd_vs2),
        .wr_point(wr_point2), .rd_point(rd_point2),
        .wr_baseaddr(wr_baseaddr2), .rd_baseaddr(rd_baseaddr2),
        .frame_valid(frame_valid2), .rd_new(rd_new2), .rd_repeat(rd_repeat2),
        .wr_overwrite(wr_overwrite2), .frame_cnt(frame_cnt2), .drop_cnt(drop_cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Raise the sync level(s); after return the update edge has just passed.
    task automatic edge_cycle(input logic wr, input logic rd, input logic done);
        wr_vs = wr;
        rd_vs = rd;
        step();
        wr_done = done;
        step();
        wr_done = 1'b0;
        wr_vs   = 1'b0;
        rd_vs   = 1'b0;
    endtask

    task automatic edge2(input logic wr, input logic rd);
        wr_vs2 = wr;
        rd_vs2 = rd;
        step();
        step();
        wr_vs2 = 1'b0;
        rd_vs2 = 1'b0;
    endtask

    task automatic done_pulse();
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1;
        wr_vs = 1'b0; wr_done = 1'b0; rd_vs = 1'b0;
        wr_vs2 = 1'b0; wr_done2 = 1'b0; rd_vs2 = 1'b0;
        idle(2);
        check("rst_wr_point", 32'(wr_point), 32'd0);
        check("rst_rd_point", 32'(rd_point), 32'd2);
        check("rst_wr_base", 32'(wr_baseaddr), 32'h0100_0000);
        check("rst_rd_base", 32'(rd_baseaddr), 32'h0200_0000);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_fcnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        idle(2);

        edge_cycle(1'b1, 1'b0, 1'b0);
        check("open_wr_point", 32'(wr_point), 32'd0);
        check("open_fcnt", 32'(frame_cnt), 32'd0);
        check("open_dcnt", 32'(drop_cnt), 32'd0);
        idle(2);
        done_pulse();
        idle(1);
        edge_cycle(1'b1, 1'b0, 1'b0);
        check("commit_wr_point", 32'(wr_point), 32'd1);
        check("commit_wr_base", 32'(wr_baseaddr), 32'h0180_0000);
        check("commit_valid", 32'(frame_valid), 32'd1);
        check("commit_fcnt", 32'(frame_cnt), 32'd1);
        idle(2);

        edge_cycle(1'b0, 1'b1, 1'b0);
        check("rdnew_rd_point", 32'(rd_point), 32'd0);
        check("rdnew_pulse", 32'(rd_new), 32'd1);
        check("rdnew_no_repeat", 32'(rd_repeat), 32'd0);
        check("rdnew_rd_base", 32'(rd_baseaddr), 32'h0100_0000);
        step();
        check("rdnew_pulse_end", 32'(rd_new), 32'd0);
        idle(1);

        edge_cycle(1'b1, 1'b0, 1'b0);
        check("drop_dcnt", 32'(drop_cnt), 32'd1);
        check("drop_wr_point", 32'(wr_point), 32'd1);
        check("drop_fcnt", 32'(frame_cnt), 32'd1);
        check("drop_valid", 32'(frame_valid), 32'd1);
        idle(2);
        edge_cycle(1'b0, 1'b1, 1'b0);
        check("rep_pulse", 32'(rd_repeat), 32'd1);
        check("rep_no_new", 32'(rd_new), 32'd0);
        check("rep_rd_point", 32'(rd_point), 32'd0);
        idle(2);

        // Simultaneous edges, wr_done coincident with the closing edge.
        edge_cycle(1'b1, 1'b1, 1'b1);
        check("sim_rep_pulse", 32'(rd_repeat), 32'd1);
        check("sim_rd_point", 32'(rd_point), 32'd0);
        check("sim_wr_point", 32'(wr_point), 32'd2);
        check("sim_fcnt", 32'(frame_cnt), 32'd2);
        check("sim_dcnt", 32'(drop_cnt), 32'd1);
        idle(2);
        edge_cycle(1'b0, 1'b1, 1'b0);
        check("latest1_rd_point", 32'(rd_point), 32'd1);
        check("latest1_rd_new", 32'(rd_new), 32'd1);
        idle(2);

        done_pulse();
        edge_cycle(1'b1, 1'b0, 1'b0);
        check("wrap_wr_point", 32'(wr_point), 32'd0);
        check("wrap_fcnt", 32'(frame_cnt), 32'd3);
        idle(2);
        done_pulse();
        edge_cycle(1'b1, 1'b0, 1'b0);
        check("skip_wr_point", 32'(wr_point), 32'd2);
        check("skip_valid", 32'(frame_valid), 32'd1);
        check("skip_fcnt", 32'(frame_cnt), 32'd4);
        idle(2);

        enable = 1'b0;
        done_pulse();
        edge_cycle(1'b1, 1'b1, 1'b1);
        idle(2);
        check("frz_wr_point", 32'(wr_point), 32'd2);
        check("frz_rd_point", 32'(rd_point), 32'd1);
        check("frz_fcnt", 32'(frame_cnt), 32'd4);
        check("frz_dcnt", 32'(drop_cnt), 32'd1);
        check("frz_pulses", 32'({rd_new, rd_repeat, wr_overwrite}), 32'd0);
        enable = 1'b1;
        idle(2);

        // Asynchronous reset while a completed frame is still open.
        done_pulse();
        #3;
        rst = 1'b1;
        #1;
        check("arst_wr_point", 32'(wr_point), 32'd0);
        check("arst_rd_point", 32'(rd_point), 32'd2);
        check("arst_valid", 32'(frame_valid), 32'd0);
        check("arst_fcnt", 32'(frame_cnt), 32'd0);
        check("arst_dcnt", 32'(drop_cnt), 32'd0);
        step();
        rst = 1'b0;
        idle(2);
        edge_cycle(1'b1, 1'b0, 1'b0);
        check("post_rst_open_wr", 32'(wr_point), 32'd0);
        check("post_rst_open_fcnt", 32'(frame_cnt), 32'd0);
        check("post_rst_open_dcnt", 32'(drop_cnt), 32'd0);
        idle(2);
        edge_cycle(1'b1, 1'b0, 1'b0);
        check("post_rst_drop", 32'(drop_cnt), 32'd1);
        idle(2);

        check("b2_rst_rd_point", 32'(rd_point2), 32'd1);
        check("b2_rst_rd_base", 32'(rd_baseaddr2), 32'h0180_0000);
        edge2(1'b1, 1'b0);
        idle(2);
        wr_done2 = 1'b1;
        step();
        wr_done2 = 1'b0;
        edge2(1'b1, 1'b0);
        check("b2_wr_point", 32'(wr_point2), 32'd0);
        check("b2_overwrite", 32'(wr_overwrite2), 32'd1);
        check("b2_valid", 32'(frame_valid2), 32'd0);
        check("b2_fcnt", 32'(frame_cnt2), 32'd1);
        step();
        check("b2_overwrite_end", 32'(wr_overwrite2), 32'd0);
        idle(1);
        edge2(1'b0, 1'b1);
        check("b2_rep_pulse", 32'(rd_repeat2), 32'd1);
        check("b2_rd_point", 32'(rd_point2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vdma_frame_scheduler.md
VDMA_FRAME_SCHEDULER -- requirements
Module: vdma_frame_scheduler

Interface
REQ-001 SHALL have parameter ASIZE, default 29, address width.
REQ-002 SHALL have parameter BUF_NUM, default 3, frame buffer count, legal 2..8.
REQ-003 SHALL have parameter BASE_ADDR, default 0, address of buffer 0.
REQ-004 SHALL have parameter FRAME_STRIDE, default 32'h0080_0000, byte distance between buffers.
REQ-005 SHALL have port clock  in  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable  in  1  1 = scheduling active; 0 = all state frozen, edges ignored.
REQ-008 SHALL have port wr_vs  in  1  writer frame sync level; rising edge = writer frame start.
REQ-009 SHALL have port wr_done  in  1  one-cycle pulse, writer finished last burst of current frame.
REQ-010 SHALL have port rd_vs  in  1  reader frame sync level; rising edge = reader frame start.
REQ-011 SHALL have ports wr_point, rd_point  out  3  buffer indices.
REQ-012 SHALL have ports wr_baseaddr, rd_baseaddr  out  ASIZE  BASE_ADDR + point*FRAME_STRIDE, truncated to ASIZE.
REQ-013 SHALL have port frame_valid  out  1  a committed, unread-safe frame exists.
REQ-014 SHALL have ports rd_new, rd_repeat, wr_overwrite  out  1  one-cycle status pulses.
REQ-015 SHALL have ports frame_cnt, drop_cnt  out  16  committed / discarded frame counters, wrap at 16'hFFFF->0.

Function
REQ-016 Edge detect: wr_vs, rd_vs registered once; edge = cur & ~prev; point updates appear the cycle after the edge cycle (latency 1 from edge-detected cycle, 2 from input rise).
REQ-017 Writer state: IDLE (no frame open) and OPEN; done flag set by wr_done in OPEN, ignored in IDLE.
REQ-018 wr edge in IDLE: -> OPEN, wr_point unchanged, done cleared.
REQ-019 wr edge in OPEN with done=1: latest <= wr_point, frame_valid <= 1, frame_cnt+1, then advance wr_point; done cleared.
REQ-020 wr edge in OPEN with done=0: frame discarded, drop_cnt+1, wr_point unchanged, latest/frame_valid unchanged.
REQ-021 Advance: candidate (wr_point+1) mod BUF_NUM; if equal to next-state rd_point, use (wr_point+2) mod BUF_NUM; if that also equals rd_point (BUF_NUM=2), stay and pulse wr_overwrite.
REQ-022 If new wr_point equals latest, frame_valid <= 0 (frame being overwritten).
REQ-023 rd edge with frame_valid=1 and latest != rd_point: rd_point <= latest, pulse rd_new; otherwise rd_point held, pulse rd_repeat.
REQ-024 Simultaneous wr and rd edge: reader evaluated on pre-cycle latest/frame_valid; writer advance then avoids updated rd_point; wr_point never equals rd_point after any advance when BUF_NUM>=3.
REQ-025 wr_done coincident with wr edge: belongs to the closing frame (counts as done).
REQ-026 Addresses combinational from registered points; no other combinational input-to-output paths.

Reset
REQ-027 rst=1 asynchronously: wr_point=0, rd_point=BUF_NUM-1, latest=0, frame_valid=0, writer IDLE, done=0, edge registers=0, all pulses 0, counters 0.
REQ-028 Reset mid-frame discards the open frame without incrementing drop_cnt; first wr edge after release only opens a frame.

Verification (BUF_NUM=3, BASE_ADDR=32'h0100_0000, FRAME_STRIDE=32'h0080_0000, enable=1)
REQ-029 Reset -> wr_point 0, rd_point 2, wr_baseaddr 29'h0100_0000, rd_baseaddr 29'h0200_0000, frame_valid 0.
REQ-030 wr edge, wr_done, wr edge -> wr_point 1, latest 0, frame_valid 1, frame_cnt 1; then rd edge -> rd_point 0, rd_new one cycle.
REQ-031 From REQ-030 state, wr edge without wr_done -> wr_point 1, drop_cnt 1; rd edge -> rd_repeat, rd_point 0.
REQ-032 wr_point 1 done, rd_point 0, latest 0, wr and rd edges same cycle -> rd_repeat, latest 1, wr_point 2.
REQ-033 BUF_NUM=2, wr_point 0, rd_point 1, closing wr edge with done -> wr_point 0, wr_overwrite pulse, frame_valid 0.
REQ-034 enable=0 during wr edge and wr_done -> no state or counter change; rst asserted mid-frame -> all REQ-027 values within same cycle.
